// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Package : mac_pkg
// Shared types and arithmetic helpers for the vector MAC datapath:
// saturating add, clamp limits and lane slicing.
// Rev 1.0 : initial release
// ============================================================================
package mac_pkg;

   // Wide working width; any OUTW below this can be saturated by sat_add.
   localparam int SAT_W = 128;

   typedef logic signed [SAT_W-1:0] wide_t;

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    clamped;
   } sat_res_t;

   function automatic int term_width(input int inw, input int lanes);
      return 2 * inw + $clog2(lanes);
   endfunction

   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction

   // Largest positive w-bit value, sign-extended to SAT_W.
   function automatic wide_t max_val(input int w);
      wide_t m;
      m = '1;
      return ~(m << (w - 1));
   endfunction

   // Most negative w-bit value, sign-extended to SAT_W.
   function automatic wide_t min_val(input int w);
      wide_t m;
      m = '1;
      return m << (w - 1);
   endfunction

   // Add two sign-extended w-bit values, clamping to the w-bit range.
   function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int w);
      sat_res_t r;
      wide_t    s;
      logic     ovf;
      s   = a + b;
      ovf = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
      r.clamped = ovf;
      if (!ovf)
         r.sum = s;
      else if (a[w-1])
         r.sum = min_val(w);
      else
         r.sum = max_val(w);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane_sum.sv
`default_nettype none
// ============================================================================
// Module : mac_lane_sum
// Combinational LANES-wide signed multiply followed by a pairwise adder tree.
// Rev 1.0 : initial release
// ============================================================================
module mac_lane_sum
   import mac_pkg::*;
#(
   parameter  int INW   = 16,
   parameter  int LANES = 4,
   localparam int TW    = term_width(INW, LANES)
) (
   input  logic [LANES*INW-1:0] in0,
   input  logic [LANES*INW-1:0] in1,
   output logic signed [TW-1:0] sum
);

   logic signed [2*INW-1:0] prod [LANES];

   genvar k;
   for (k = 0; k < LANES; k++) begin : g_lane
      logic signed [INW-1:0] a;
      logic signed [INW-1:0] b;
      assign a       = in0[lane_lo(k, INW) +: INW];
      assign b       = in1[lane_lo(k, INW) +: INW];
      assign prod[k] = (2*INW)'(a) * (2*INW)'(b);
   end

   // Pairwise reduction: each pass halves the number of live partial sums.
   always_comb begin : p_tree
      logic signed [TW-1:0] v [LANES];
      for (int j = 0; j < LANES; j++)
         v[j] = TW'(prod[j]);
      for (int st = 1; st < LANES; st = st * 2)
         for (int j = 0; j + st < LANES; j = j + 2 * st)
            v[j] = v[j] + v[j+st];
      sum = v[0];
   end

endmodule
`default_nettype wire

// File: rtl/mac_vec_pipe.sv
`default_nettype none
// ============================================================================
// Module : mac_vec_pipe
// Multi-lane pipelined saturating dot-product engine with valid/ready I/O.
// Rev 1.0 : initial release
// ============================================================================
module mac_vec_pipe
   import mac_pkg::*;
#(
   parameter int INW     = 16,
   parameter int OUTW    = 48,
   parameter int LANES   = 4,
   parameter int MSTAGES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*INW-1:0] in0,
   input  logic [LANES*INW-1:0] in1,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUTW-1:0]      out_data,
   output logic                 out_sat
);

   localparam int TW = term_width(INW, LANES);

   if (OUTW < TW || OUTW >= SAT_W) begin : g_bad_outw
      $error("mac_vec_pipe: OUTW out of range for INW/LANES");
   end
   if (LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
      $error("mac_vec_pipe: LANES must be a power of two");
   end
   if (MSTAGES < 1 || MSTAGES > 3) begin : g_bad_mstages
      $error("mac_vec_pipe: MSTAGES must be 1..3");
   end

   logic stall;
   logic accept;

   logic [LANES*INW-1:0] op0;
   logic [LANES*INW-1:0] op1;
   logic                 op_valid;
   logic                 op_last;

   logic signed [TW-1:0]   tree_sum;
   logic signed [OUTW-1:0] term_pipe [MSTAGES];
   logic [MSTAGES-1:0]     vld_pipe;
   logic [MSTAGES-1:0]     last_pipe;

   logic signed [OUTW-1:0] acc;
   logic                   sticky;

   sat_res_t               res;
   logic signed [OUTW-1:0] acc_sum;
   logic                   unused_hi;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   mac_lane_sum #(
      .INW   (INW),
      .LANES (LANES)
   ) u_lane_sum (
      .in0 (op0),
      .in1 (op1),
      .sum (tree_sum)
   );

   assign res       = sat_add(SAT_W'(acc), SAT_W'(term_pipe[MSTAGES-1]), OUTW);
   assign acc_sum   = res.sum[OUTW-1:0];
   assign unused_hi = &{1'b0, res.sum[SAT_W-1:OUTW]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op0       <= '0;
         op1       <= '0;
         op_valid  <= 1'b0;
         op_last   <= 1'b0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         for (int s = 0; s < MSTAGES; s++)
            term_pipe[s] <= '0;
         acc       <= '0;
         sticky    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (!stall) begin
         op_valid <= accept;
         if (accept) begin
            op0     <= in0;
            op1     <= in1;
            op_last <= in_last;
         end

         if (op_valid)
            term_pipe[0] <= OUTW'(tree_sum);
         vld_pipe[0]  <= op_valid;
         last_pipe[0] <= op_last;
         for (int s = 1; s < MSTAGES; s++) begin
            term_pipe[s] <= term_pipe[s-1];
            vld_pipe[s]  <= vld_pipe[s-1];
            last_pipe[s] <= last_pipe[s-1];
         end

         // Not stalled means any held result is consumed this edge.
         out_valid <= vld_pipe[MSTAGES-1] && last_pipe[MSTAGES-1];
         if (vld_pipe[MSTAGES-1]) begin
            if (last_pipe[MSTAGES-1]) begin
               out_data <= acc_sum;
               out_sat  <= sticky | res.clamped;
               acc      <= '0;
               sticky   <= 1'b0;
            end else begin
               acc      <= acc_sum;
               sticky   <= sticky | res.clamped;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mac_vec_pipe.md
Name: mac_vec_pipe

Overview:
- Parametrised successor to the single-lane pipelined saturating MAC.
- Each accepted beat multiplies LANES signed operand pairs in parallel and reduces them through an adder tree.
- The reduced term passes through a configurable pipeline, then is accumulated with saturation over a variable-length vector delimited by in_last.
- Completed dot products leave on a valid/ready output with a sticky saturation flag. The block sits between operand buffers and the result writeback in the matrix-vector datapath.

Parameters:
INW, 16, signed operand width per lane
OUTW, 48, accumulator/result width; elaboration error unless OUTW >= 2*INW + $clog2(LANES)
LANES, 4, parallel multiply lanes per beat (power of two, >= 1)
MSTAGES, 1, pipeline registers between the multiply/adder tree and the accumulator (1..3)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  beat present on in0/in1/in_last
in_ready  out  1  block accepts beat this cycle
in0  in  LANES*INW  packed signed operands, lane k at [k*INW +: INW]
in1  in  LANES*INW  packed signed operands, same packing
in_last  in  1  final beat of the current vector
out_valid  out  1  out_data/out_sat hold a completed result
out_ready  in  1  consumer takes result this cycle
out_data  out  OUTW  signed saturated dot product
out_sat  out  1  saturation occurred at any beat of this vector

Behaviour:
- Reset (reset low, asynchronous): pipeline valids, accumulator, out_valid, out_data and out_sat all go to 0. in_ready is 1 one cycle after reset releases. Reset mid-vector discards partial sums; no result is emitted.
- Accept: a beat transfers on a rising edge with in_valid && in_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall is high, every pipeline register, valid/last bit, the accumulator and the output register hold.
- Arithmetic:
  - Lane products are full-precision signed (2*INW).
  - The tree sum is sign-extended to 2*INW + clog2(LANES) bits, then to OUTW bits. The term itself never overflows.
  - Invalid beats carry valid=0 and do not touch the accumulator (no zero-injection).
- Accumulate: acc_next = sat(acc + term).
  - Overflow is detected as same operand signs with a flipped result sign.
  - Clamp to MAXVAL = 2^(OUTW-1)-1 on positive overflow, MINVAL = -2^(OUTW-1) on negative overflow.
  - A per-vector sticky flag is set on any clamp.
  - Once the accumulator saturates, later terms of opposite sign do add back from the clamped value; no latching.
- Completion: when a beat with last=1 reaches the accumulator stage:
  - out_data <= sat(acc + term); out_sat <= sticky | this beat's clamp; out_valid <= 1.
  - Accumulator and sticky flag clear to 0, so the next beat starts a new vector with no bubble.
- Latency: a last beat accepted at edge t gives out_valid high after edge t+MSTAGES+1, counting only non-stalled edges. MSTAGES=1 gives 2 edges.
- Output handshake:
  - out_data/out_sat are stable while out_valid && !out_ready.
  - If out_ready=1 in the same cycle a new result arrives, the register is overwritten with no gap.
  - out_valid drops after a transfer if no new result arrives.
- Single-beat vectors (in_valid && in_last every beat) are legal and produce one result per beat.
- in0/in1/in_last are ignored when in_valid=0.

Decomposition:
- Package mac_pkg holds:
  - function sat_add(a, b) returning {sum, clamped}
  - MAXVAL/MINVAL derivation from OUTW
  - lane slice helper functions
- Sub-module mac_lane_sum: purely combinational LANES multiplies plus adder tree; output width 2*INW + clog2(LANES).
- mac_vec_pipe owns the pipeline, stall logic, accumulator and output register.

Test Plan:
- Default params, one beat: all in0 lanes = 2, all in1 lanes = 3, in_last=1, out_ready=1 -> out_data=24, out_sat=0, out_valid high exactly 2 edges after accept for 1 cycle.
- Three-beat vector (lanes (1,-1,5,0) x (7,7,-2,9), then all lanes 100x100, then all lanes -3x4, last on beat 3) -> out_data = -10 + 40000 - 48 = 39942.
- OUTW=34 override: 2 beats of all lanes -32768 x -32768 (2^32 per beat) -> out_data = 2^33-1, out_sat=1. The next single-beat vector of 1x1 lanes -> out_data=4, out_sat=0 (flag cleared).
- Backpressure: a result arrives with out_ready=0 for 5 cycles -> out_data stable, in_ready=0 and no beat accepted during stall. out_ready=1 -> transfer; in_ready=1 the following cycle.
- Reset mid-vector: accept 2 non-last beats, pulse reset low (asynchronous, mid-cycle), then a single-beat vector of all lanes 1x1 -> out_data=4, no earlier result emitted.
- Streaming: 8 consecutive single-beat vectors with out_ready=1 -> 8 back-to-back out_valid cycles with no bubbles, values in order.
